mio_stall_ctrl: RTL

Memory/IO access sequencer between the single-cycle CPU control unit and the MIO bus. When control asserts CPU_MIO for a load or store, it freezes the CPU with stall, drives a registered bus request, and waits for MIO_ready. It then releases the CPU for exactly one commit cycle with read data held stable. A timeout counter bounds the wait and raises a sticky error.

---
 rtl/mio_stall_ctrl_pkg.sv | 20 ++
 rtl/mio_timeout_cnt.sv | 29 ++
 rtl/mio_stall_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/mio_stall_ctrl_pkg.sv
// Shared types for the MIO access sequencer.
// State encodings and the data returned on an aborted access.
package mio_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    MIO_IDLE = 2'd0,
    MIO_REQ  = 2'd1,
    MIO_WAIT = 2'd2,
    MIO_DONE = 2'd3
  } mio_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mio_req_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/mio_timeout_cnt.sv
// Saturating wait counter for the MIO sequencer.
// tc flags the last allowed cycle; TIMEOUT of 0 never flags.
module mio_timeout_cnt #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (TIMEOUT != 0) &&
              (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mio_stall_ctrl.sv
// Stalls the CPU around one MIO bus access and
// releases it for a single commit cycle.
module mio_stall_ctrl
  import mio_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPU_MIO,
  input  logic        MemRW,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic        MIO_ready,
  input  logic [31:0] Data_from_bus,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [31:0] rdata_out,
  output logic        busy,
  output logic        mem_timeout
);

  mio_state_e state_q;
  mio_state_e state_d;
  mio_req_t   req_q;

  logic capture;
  logic in_bus;
  logic tc;
  logic abort;

  assign capture = (state_q == MIO_IDLE) && CPU_MIO;
  assign in_bus  = (state_q == MIO_REQ) ||
                   (state_q == MIO_WAIT);
  assign abort   = (state_q == MIO_WAIT) &&
                   tc && !MIO_ready;

  // Counter reads 1 in REQ, so tc lands on the
  // last WAIT cycle of the allowed window.
  mio_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == MIO_DONE),
    .en  (capture || in_bus),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MIO_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MIO_IDLE: begin
        if (CPU_MIO) state_d = MIO_REQ;
      end
      MIO_REQ: begin
        state_d = MIO_ready ? MIO_DONE
                            : MIO_WAIT;
      end
      MIO_WAIT: begin
        if (MIO_ready || tc) state_d = MIO_DONE;
      end
      MIO_DONE: state_d = MIO_IDLE;
      default:  state_d = MIO_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      bus_req     <= 1'b0;
      rdata_out   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      bus_req <= (state_d == MIO_REQ) ||
                 (state_d == MIO_WAIT);
      if (capture) begin
        req_q.we    <= MemRW;
        req_q.addr  <= Addr_in;
        req_q.wdata <= Data_in;
      end
      if (in_bus && MIO_ready && !req_q.we) begin
        rdata_out <= Data_from_bus;
      end
      if (abort) begin
        mem_timeout <= 1'b1;
        rdata_out   <= TIMEOUT_DATA;
      end
    end
  end

  // Reset forces stall low even while CPU_MIO is held.
  assign stall     = !rst && (capture || in_bus);
  assign busy      = (state_q != MIO_IDLE);
  assign bus_we    = req_q.we;
  assign bus_addr  = req_q.addr;
  assign bus_wdata = req_q.wdata;

endmodule
